// File: rtl/clock_pkg.sv
// Shared types for the clock setter: mode encodings and BCD field maxima.
// Imported by the interface, the BCD counter and the top level.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      SET_SEC  = 2'b11
   } mode_t;

   localparam logic [7:0] SEC_MAX  = 8'h59;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] HOUR_MAX = 8'h23;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bundle between the clock controller and its user.
// Inputs: tick_1hz, mode_btn, inc_btn (one-cycle pulses).
// Outputs: hour/min/sec BCD, mode, blink, carry_day.
interface clock_set_ctrl_if;
   import clock_pkg::*;

   logic       tick_1hz;
   logic       mode_btn;
   logic       inc_btn;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   mode_t      mode;
   logic       blink;
   logic       carry_day;

   modport master (
      output tick_1hz, mode_btn, inc_btn,
      input  hour_bcd, min_bcd, sec_bcd,
      input  mode, blink, carry_day
   );

   modport slave (
      input  tick_1hz, mode_btn, inc_btn,
      output hour_bcd, min_bcd, sec_bcd,
      output mode, blink, carry_day
   );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping MAX -> 00.
// Ports: CP, reset (sync, active-low), inc, value[7:0], wrap (comb).
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX = SEC_MAX
) (
   input  logic       CP,
   input  logic       reset,
   input  logic       inc,
   output logic [7:0] value,
   output logic       wrap
);

   logic [3:0] lo;
   logic [3:0] hi;

   assign lo   = value[3:0];
   assign hi   = value[7:4];
   assign wrap = inc & (value == MAX);

   always_ff @(posedge CP) begin
      if (!reset) begin
         value <= 8'h00;
      end else if (inc) begin
         if (value == MAX)
            value <= 8'h00;
         else if (lo == 4'd9)
            value <= {hi + 4'd1, 4'h0};
         else
            value <= {hi, lo + 4'd1};
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day clock with RUN and three field-set modes plus blink strobe.
// Ports: CP, reset (sync, active-low), bus (clock_set_ctrl_if.slave).
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int BLINK_CYCLES = 16
) (
   input  logic             CP,
   input  logic             reset,
   clock_set_ctrl_if.slave  bus
);

   localparam int CW = $clog2(BLINK_CYCLES + 1);

   mode_t         mode;
   mode_t         mode_n;
   logic          blink;
   logic          blink_n;
   logic          carry_day;
   logic          carry_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;

   logic       run;
   logic       inc_ok;
   logic       sec_inc;
   logic       min_inc;
   logic       hour_inc;
   logic       sec_wrap;
   logic       min_wrap;
   logic       hour_wrap;
   logic [7:0] hours;
   logic [7:0] mins;
   logic [7:0] secs;

   assign run    = (mode == RUN);
   // A mode press swallows a coincident inc press.
   assign inc_ok = bus.inc_btn & ~bus.mode_btn;

   // In RUN the fields chain through their wrap outputs; in set modes
   // only the selected field moves and nothing carries.
   assign sec_inc  = run ? bus.tick_1hz : (inc_ok & (mode == SET_SEC));
   assign min_inc  = run ? sec_wrap     : (inc_ok & (mode == SET_MIN));
   assign hour_inc = run ? min_wrap     : (inc_ok & (mode == SET_HOUR));

   bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .CP    (CP),
      .reset (reset),
      .inc   (sec_inc),
      .value (secs),
      .wrap  (sec_wrap)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
      .CP    (CP),
      .reset (reset),
      .inc   (min_inc),
      .value (mins),
      .wrap  (min_wrap)
   );

   bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
      .CP    (CP),
      .reset (reset),
      .inc   (hour_inc),
      .value (hours),
      .wrap  (hour_wrap)
   );

   always_ff @(posedge CP) begin
      if (!reset) begin
         mode      <= RUN;
         blink     <= 1'b0;
         cnt       <= '0;
         carry_day <= 1'b0;
      end else begin
         mode      <= mode_n;
         blink     <= blink_n;
         cnt       <= cnt_n;
         carry_day <= carry_n;
      end
   end

   always_comb begin
      mode_n  = mode;
      blink_n = blink;
      cnt_n   = cnt;
      carry_n = run & hour_wrap;

      if (bus.mode_btn) begin
         unique case (mode)
            RUN:      mode_n = SET_HOUR;
            SET_HOUR: mode_n = SET_MIN;
            SET_MIN:  mode_n = SET_SEC;
            SET_SEC:  mode_n = RUN;
         endcase
      end

      // Entering a set mode or editing restarts the blink phase lit.
      if (mode_n == RUN) begin
         blink_n = 1'b0;
         cnt_n   = '0;
      end else if (bus.mode_btn | bus.inc_btn) begin
         blink_n = 1'b1;
         cnt_n   = '0;
      end else if (cnt == CW'(BLINK_CYCLES - 1)) begin
         blink_n = ~blink;
         cnt_n   = '0;
      end else begin
         cnt_n = cnt + CW'(1);
      end
   end

   assign bus.hour_bcd  = hours;
   assign bus.min_bcd   = mins;
   assign bus.sec_bcd   = secs;
   assign bus.mode      = mode;
   assign bus.blink     = blink;
   assign bus.carry_day = carry_day;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector table plus
// scoreboarded sequences driven against an integer time model.
module tb_clock_set_ctrl;
   import clock_pkg::*;

   localparam int BC = 16;

   typedef struct packed {
      logic [7:0] h;
      logic [7:0] mi;
      logic [7:0] s;
      mode_t      md;
      logic       b;
      logic       c;
   } exp_t;

   typedef struct {
      logic       t;
      logic       m;
      logic       i;
      logic [7:0] h;
      logic [7:0] mi;
      logic [7:0] s;
      mode_t      md;
      logic       b;
      logic       c;
   } vec_t;

   logic CP = 1'b0;
   logic reset = 1'b0;

   clock_set_ctrl_if bus ();

   clock_set_ctrl #(.BLINK_CYCLES(BC)) dut (
      .CP    (CP),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 CP = ~CP;

   exp_t sb[$];
   vec_t tbl[14];
   int   checks = 0;
   int   errors = 0;
   int   stepno = 0;

   int mh, mm, ms, mmode, mblink, mcnt, mcarry;

   function automatic logic [7:0] bcd(input int x);
      return {4'(x / 10), 4'(x % 10)};
   endfunction

   function automatic exp_t cur_exp();
      exp_t e;
      e.h  = bcd(mh);
      e.mi = bcd(mm);
      e.s  = bcd(ms);
      e.md = mode_t'(mmode[1:0]);
      e.b  = mblink[0];
      e.c  = mcarry[0];
      return e;
   endfunction

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @step %0d: got %h expected %h",
                  name, stepno, act, exp);
      end
   endtask

   task automatic model_reset();
      mh = 0; mm = 0; ms = 0;
      mmode = 0; mblink = 0; mcnt = 0; mcarry = 0;
   endtask

   task automatic model_step(input logic t, input logic m, input logic i);
      int nm;
      mcarry = 0;
      if (mmode == 0) begin
         if (t) begin
            ms++;
            if (ms == 60) begin
               ms = 0; mm++;
               if (mm == 60) begin
                  mm = 0; mh++;
                  if (mh == 24) begin
                     mh = 0; mcarry = 1;
                  end
               end
            end
         end
      end else if (i && !m) begin
         case (mmode)
            1:       mh = (mh + 1) % 24;
            2:       mm = (mm + 1) % 60;
            default: ms = (ms + 1) % 60;
         endcase
      end
      nm = m ? (mmode + 1) % 4 : mmode;
      if (nm == 0) begin
         mblink = 0; mcnt = 0;
      end else if (m || i) begin
         mblink = 1; mcnt = 0;
      end else if (mcnt == BC - 1) begin
         mblink = 1 - mblink; mcnt = 0;
      end else begin
         mcnt++;
      end
      mmode = nm;
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard: got empty queue expected entry");
         return;
      end
      e = sb.pop_front();
      chk("hour",  bus.hour_bcd, e.h);
      chk("min",   bus.min_bcd, e.mi);
      chk("sec",   bus.sec_bcd, e.s);
      chk("mode",  {6'b0, bus.mode}, {6'b0, e.md});
      chk("blink", {7'b0, bus.blink}, {7'b0, e.b});
      chk("carry", {7'b0, bus.carry_day}, {7'b0, e.c});
   endtask

   task automatic drive(input logic t, input logic m, input logic i);
      bus.tick_1hz = t;
      bus.mode_btn = m;
      bus.inc_btn  = i;
   endtask

   task automatic finish_edge();
      @(posedge CP);
      #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      stepno++;
      check_out();
   endtask

   task automatic step(input logic t, input logic m, input logic i);
      @(negedge CP);
      drive(t, m, i);
      model_step(t, m, i);
      sb.push_back(cur_exp());
      finish_edge();
   endtask

   task automatic do_reset(input logic t, input logic m, input logic i);
      @(negedge CP);
      reset = 1'b0;
      drive(t, m, i);
      model_reset();
      sb.push_back(cur_exp());
      finish_edge();
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge CP);
      drive(v.t, v.m, v.i);
      model_step(v.t, v.m, v.i);
      e.h = v.h; e.mi = v.mi; e.s = v.s;
      e.md = v.md; e.b = v.b; e.c = v.c;
      sb.push_back(e);
      finish_edge();
   endtask

   task automatic incs(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic preload(input int h, input int m, input int s);
      step(1'b0, 1'b1, 1'b0);
      incs(h);
      step(1'b0, 1'b1, 1'b0);
      incs(m);
      step(1'b0, 1'b1, 1'b0);
      incs(s);
      step(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'h01,RUN,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b1,8'h00,8'h00,8'h01,RUN,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b1,1'b0,8'h00,8'h00,8'h01,SET_HOUR,1'b1,1'b0};
      tbl[3]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'h01,SET_HOUR,1'b1,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b1,8'h01,8'h00,8'h01,SET_HOUR,1'b1,1'b0};
      tbl[5]  = '{1'b0,1'b1,1'b1,8'h01,8'h00,8'h01,SET_MIN,1'b1,1'b0};
      tbl[6]  = '{1'b1,1'b0,1'b1,8'h01,8'h01,8'h01,SET_MIN,1'b1,1'b0};
      tbl[7]  = '{1'b0,1'b1,1'b0,8'h01,8'h01,8'h01,SET_SEC,1'b1,1'b0};
      tbl[8]  = '{1'b0,1'b0,1'b1,8'h01,8'h01,8'h02,SET_SEC,1'b1,1'b0};
      tbl[9]  = '{1'b0,1'b1,1'b0,8'h01,8'h01,8'h02,RUN,1'b0,1'b0};
      tbl[10] = '{1'b1,1'b1,1'b0,8'h01,8'h01,8'h03,SET_HOUR,1'b1,1'b0};
      tbl[11] = '{1'b0,1'b1,1'b0,8'h01,8'h01,8'h03,SET_MIN,1'b1,1'b0};
      tbl[12] = '{1'b0,1'b1,1'b0,8'h01,8'h01,8'h03,SET_SEC,1'b1,1'b0};
      tbl[13] = '{1'b1,1'b1,1'b1,8'h01,8'h01,8'h03,RUN,1'b0,1'b0};

      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge CP);

      // reset overriding active inputs
      do_reset(1'b1, 1'b1, 1'b1);

      for (int v = 0; v < 14; v++) apply(tbl[v]);

      // 60 ticks from reset
      do_reset(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 60; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (k == 58) chk("sec_at_59", bus.sec_bcd, 8'h59);
      end
      chk("sec_after_60", bus.sec_bcd, 8'h00);
      chk("min_after_60", bus.min_bcd, 8'h01);

      // day rollover
      do_reset(1'b0, 1'b0, 1'b0);
      preload(23, 59, 59);
      chk("pre_hour", bus.hour_bcd, 8'h23);
      step(1'b1, 1'b0, 1'b0);
      chk("roll_carry", {7'b0, bus.carry_day}, 8'h01);
      chk("roll_hour", bus.hour_bcd, 8'h00);
      step(1'b0, 1'b0, 1'b0);
      chk("carry_drop", {7'b0, bus.carry_day}, 8'h00);

      // minute wrap in SET_MIN, ticks frozen
      do_reset(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      incs(5);
      step(1'b0, 1'b1, 1'b0);
      incs(59);
      chk("min_59", bus.min_bcd, 8'h59);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("min_wrap", bus.min_bcd, 8'h00);
      chk("hour_kept", bus.hour_bcd, 8'h05);
      chk("sec_frozen", bus.sec_bcd, 8'h00);

      // mode+inc together in SET_HOUR
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      chk("mi_mode", {6'b0, bus.mode}, {6'b0, SET_MIN});
      chk("mi_hour", bus.hour_bcd, 8'h05);

      // blink divider in SET_SEC
      step(1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         step(1'b0, 1'b0, 1'b0);
         chk("blink_div", {7'b0, bus.blink},
             ((k / 16) % 2 == 0) ? 8'h01 : 8'h00);
      end
      repeat (10) step(1'b0, 1'b0, 1'b0);
      chk("blink_low", {7'b0, bus.blink}, 8'h00);
      step(1'b0, 1'b0, 1'b1);
      chk("blink_force", {7'b0, bus.blink}, 8'h01);
      repeat (17) step(1'b0, 1'b0, 1'b0);

      // reset mid-SET_MIN at 12:34:56
      do_reset(1'b0, 1'b0, 1'b0);
      preload(12, 34, 56);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("pre_min", bus.min_bcd, 8'h34);
      do_reset(1'b1, 1'b1, 1'b1);
      chk("rst_sec", bus.sec_bcd, 8'h00);
      chk("rst_mode", {6'b0, bus.mode}, {6'b0, RUN});

      // reset on the rollover tick
      preload(23, 59, 59);
      do_reset(1'b1, 1'b0, 1'b0);
      chk("rst_roll_carry", {7'b0, bus.carry_day}, 8'h00);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d left expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
